// File: rtl/engine_sched.sv
// Start-pulse scheduler: gives each core N_PHASES evenly spaced one-cycle start pulses
// per PERIOD-cycle round, with run/drain control and a mask that changes only between rounds.
module engine_sched #(
   parameter int N_CORES  = 3,
   parameter int N_PHASES = 2,
   parameter int PERIOD   = 144
) (
   input  logic                                 CLK,
   input  logic                                 RESET,
   input  logic                                 run,
   input  logic [N_CORES-1:0]                   core_mask,
   output logic                                 busy,
   output logic [N_CORES-1:0]                   core_start,
   output logic [N_CORES*((N_PHASES > 1) ? $clog2(N_PHASES) : 1)-1:0] core_phase
);
   localparam int PH_W     = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;
   localparam int CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int INTERVAL = PERIOD / (N_CORES * N_PHASES);
   localparam int SEG      = PERIOD / N_PHASES;

   if (PERIOD % (N_CORES * N_PHASES) != 0) begin : g_bad_period
      $error("engine_sched: PERIOD must be a multiple of N_CORES*N_PHASES");
   end
   if (INTERVAL < 1) begin : g_bad_interval
      $error("engine_sched: INTERVAL must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [CW-1:0]             drain_cnt_q, drain_cnt_d;
   logic [N_CORES-1:0]        mask_q, mask_d;
   logic [N_CORES-1:0]        start_q, start_d;
   logic [N_CORES*PH_W-1:0]   phase_q, phase_d;
   logic                      last_q;
   logic [CW-1:0]             cnt_inc;

   assign last_q  = (cnt_q == CW'(PERIOD - 1));
   assign cnt_inc = last_q ? '0 : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_cnt_d = drain_cnt_q;
      mask_d      = mask_q;
      start_d     = '0;
      phase_d     = phase_q;
      case (state_q)
         IDLE: begin
            cnt_d       = '0;
            drain_cnt_d = '0;
            if (run) begin
               state_d = RUN;
               mask_d  = core_mask;
            end
         end
         RUN: begin
            cnt_d = cnt_inc;
            // The slot on the last round cycle still sees the old mask_q.
            if (last_q) mask_d = core_mask;
            if (run) begin
               for (int i = 0; i < N_CORES; i++) begin
                  for (int p = 0; p < N_PHASES; p++) begin
                     if (mask_q[i] && int'(cnt_q) == p * SEG + i * INTERVAL) begin
                        start_d[i]                = 1'b1;
                        phase_d[i*PH_W +: PH_W]   = PH_W'(p);
                     end
                  end
               end
            end else begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            cnt_d       = cnt_inc;
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (drain_cnt_q == CW'(PERIOD - 1)) begin
               state_d     = IDLE;
               cnt_d       = '0;
               drain_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         drain_cnt_q <= '0;
         mask_q      <= '0;
         start_q     <= '0;
         phase_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drain_cnt_q <= drain_cnt_d;
         mask_q      <= mask_d;
         start_q     <= start_d;
         phase_q     <= phase_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign core_start = start_q;
   assign core_phase = phase_q;
endmodule

// File: tb/tb_engine_sched.sv
// Scoreboard bench for engine_sched: stimulus pushes expected pulses, negedge monitors pop and compare.
module tb_engine_sched;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       run = 1'b0;
   logic [2:0] core_mask = 3'b000;
   logic       busy;
   logic [2:0] core_start;
   logic [2:0] core_phase;

   logic       rst4 = 1'b1;
   logic       run4 = 1'b0;
   logic [3:0] core_mask4 = 4'hF;
   logic       busy4;
   logic [3:0] core_start4;
   logic [7:0] core_phase4;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct { int cyc; int core; int ph; } ev_t;
   ev_t qa[$];
   ev_t qb[$];

   engine_sched dut (
      .CLK(CLK), .RESET(RESET), .run(run), .core_mask(core_mask),
      .busy(busy), .core_start(core_start), .core_phase(core_phase)
   );

   engine_sched #(.N_CORES(4), .N_PHASES(3), .PERIOD(144)) dut4 (
      .CLK(CLK), .RESET(rst4), .run(run4), .core_mask(core_mask4),
      .busy(busy4), .core_start(core_start4), .core_phase(core_phase4)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
      end else begin
         $display("check %s: %0d (cyc %0d)", nm, act, cyc);
      end
   endtask

   // Default geometry: slot s -> phase s/3, core s%3, cnt = 72*p + 24*i, pulse one cycle later.
   task automatic push(input int t0, input logic [2:0] m, input int s_lo, input int s_hi);
      for (int s = s_lo; s <= s_hi; s++) begin
         int p;
         int i;
         p = s / 3;
         i = s % 3;
         if (m[i]) qa.push_back('{t0 + p * 72 + i * 24 + 1, i, p});
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   always @(negedge CLK) begin
      if (core_start != 3'b000) begin
         n_cmp++;
         if ($countones(core_start) != 1) begin
            n_bad++;
            $display("FAIL onehot: core_start=%b, expected exactly one bit (cyc %0d)", core_start, cyc);
         end
         for (int i = 0; i < 3; i++) begin
            if (core_start[i]) begin
               n_cmp++;
               if (qa.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_pulse: core %0d at cyc %0d, expected none", i, cyc);
               end else begin
                  ev_t e;
                  e = qa.pop_front();
                  if (e.cyc != cyc || e.core != i || e.ph != int'(core_phase[i])) begin
                     n_bad++;
                     $display("FAIL pulse: got cyc=%0d core=%0d ph=%0d, expected cyc=%0d core=%0d ph=%0d",
                              cyc, i, core_phase[i], e.cyc, e.core, e.ph);
                  end else begin
                     $display("pulse cyc=%0d core=%0d ph=%0d ok", cyc, i, core_phase[i]);
                  end
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (core_start4[3]) begin
         n_cmp++;
         if (qb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse4: core 3 at cyc %0d, expected none", cyc);
         end else begin
            ev_t e;
            e = qb.pop_front();
            if (e.cyc != cyc || e.ph != int'(core_phase4[7:6])) begin
               n_bad++;
               $display("FAIL pulse4: got cyc=%0d ph=%0d, expected cyc=%0d ph=%0d",
                        cyc, core_phase4[7:6], e.cyc, e.ph);
            end else begin
               $display("pulse4 cyc=%0d core=3 ph=%0d ok", cyc, core_phase4[7:6]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int t1;
      int t2;
      repeat (3) @(negedge CLK);
      chk("reset_busy", int'(busy), 0);
      chk("reset_start", int'(core_start), 0);
      chk("reset_phase", int'(core_phase), 0);
      RESET = 1'b0;
      rst4  = 1'b0;
      repeat (2) @(negedge CLK);
      chk("idle_busy", int'(busy), 0);

      // Start both instances together; first RUN cycle is the next one.
      run = 1'b1;
      run4 = 1'b1;
      core_mask = 3'b111;
      t0 = cyc + 1;
      push(t0, 3'b111, 0, 5);
      push(t0 + 144, 3'b101, 0, 5);
      push(t0 + 288, 3'b111, 0, 0);
      qb.push_back('{t0 + 37, 3, 0});
      qb.push_back('{t0 + 85, 3, 1});
      qb.push_back('{t0 + 133, 3, 2});

      wait_until(t0 + 1);
      chk("run_busy", int'(busy), 1);
      wait_until(t0 + 10);
      core_mask = 3'b101;
      wait_until(t0 + 144);
      run4 = 1'b0;
      wait_until(t0 + 154);
      core_mask = 3'b111;

      // Drop run exactly on core1's slot of round 2.
      wait_until(t0 + 288 + 24);
      run = 1'b0;
      chk("drop_busy", int'(busy), 1);
      wait_until(t0 + 350);
      run = 1'b1;
      chk("drain_busy", int'(busy), 1);
      wait_until(t0 + 456);
      chk("drain_last_busy", int'(busy), 1);
      wait_until(t0 + 457);
      chk("drain_done_busy", int'(busy), 0);

      t1 = t0 + 458;
      push(t1, 3'b111, 0, 2);
      wait_until(t1);
      chk("restart_busy", int'(busy), 1);

      // Reset while core0's phase-1 pulse is pending.
      wait_until(t1 + 72);
      RESET = 1'b1;
      #1;
      chk("midreset_start", int'(core_start), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_cnt", int'(dut.cnt_q), 0);
      chk("midreset_phase", int'(core_phase), 0);
      wait_until(t1 + 73);
      RESET = 1'b0;

      t2 = t1 + 74;
      for (int r = 0; r < 10; r++) push(t2 + 144 * r, 3'b111, 0, 5);
      wait_until(t2 + 1440);
      run = 1'b0;
      wait_until(t2 + 1450);
      chk("queue_a_left", qa.size(), 0);
      chk("queue_b_left", qb.size(), 0);
      chk("end_busy", int'(busy), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
